lock_unlock_ctrl: RTL

LOCK_UNLOCK_CTRL -- requirements
Module: lock_unlock_ctrl

---
 rtl/lock_pkg.sv | 17 +
 rtl/lock_down_counter.sv | 29 ++
 rtl/lock_unlock_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared FSM state encoding and default parameter values for the debug lock/unlock controller.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHALLENGE = 2'd1,
    ST_UNLOCKED  = 2'd2,
    ST_LOCKOUT   = 2'd3
  } lock_state_t;

  localparam int unsigned DEF_KEY_W          = 16;
  localparam int unsigned DEF_MAX_TRIES      = 3;
  localparam int unsigned DEF_KEY_WAIT       = 64;
  localparam int unsigned DEF_SESSION_CYCLES = 256;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 1024;

endpackage

// File: rtl/lock_down_counter.sv
// Saturating down-counter: load sets MAXV, enable decrements toward 0.
// expired flags the final counted cycle (count at 1 or already 0).
module lock_down_counter #(
  parameter int unsigned MAXV = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(MAXV) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MAXV);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt <= CW'(1));

endmodule

// File: rtl/lock_unlock_ctrl.sv
// Debug unlock controller: sticky lock bit plus a key challenge FSM with retry limit,
// session timeout and lockout period; every output is registered.
module lock_unlock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned KEY_W          = DEF_KEY_W,
  parameter int unsigned MAX_TRIES      = DEF_MAX_TRIES,
  parameter int unsigned KEY_WAIT       = DEF_KEY_WAIT,
  parameter int unsigned SESSION_CYCLES = DEF_SESSION_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  localparam int unsigned TW            = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             lock_req,
  input  logic             debug_en,
  input  logic             dbg_req,
  input  logic [KEY_W-1:0] dbg_key,
  input  logic             dbg_key_valid,
  input  logic             dbg_exit,
  input  logic [KEY_W-1:0] ref_key,
  output logic             lock_status,
  output logic             debug_unlocked,
  output logic             dbg_ack,
  output logic             dbg_fail,
  output logic             locked_out,
  output logic [TW-1:0]    tries_left
);

  lock_state_t state, state_nxt;

  logic          wait_expired, session_expired, lockout_expired;
  logic          start, key_ok, key_bad, last_try;
  logic          unlocked_nxt, locked_out_nxt, ack_nxt, fail_nxt;
  logic [TW-1:0] tries_nxt;

  assign start    = (state == ST_IDLE) && dbg_req && debug_en;
  assign key_ok   = (state == ST_CHALLENGE) && debug_en && dbg_key_valid && (dbg_key == ref_key);
  // A presented key always decides the attempt, even on the cycle the wait timer runs out.
  assign key_bad  = (state == ST_CHALLENGE) && debug_en &&
                    (dbg_key_valid ? (dbg_key != ref_key) : wait_expired);
  assign last_try = (tries_left == TW'(1));

  lock_down_counter #(.MAXV(KEY_WAIT)) u_wait_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .load    (start),
    .en      (state == ST_CHALLENGE),
    .expired (wait_expired)
  );

  lock_down_counter #(.MAXV(SESSION_CYCLES)) u_session_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .load    (key_ok),
    .en      (state == ST_UNLOCKED),
    .expired (session_expired)
  );

  lock_down_counter #(.MAXV(LOCKOUT_CYCLES)) u_lockout_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .load    (key_bad && last_try),
    .en      (state == ST_LOCKOUT),
    .expired (lockout_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      lock_status    <= 1'b0;
      debug_unlocked <= 1'b0;
      dbg_ack        <= 1'b0;
      dbg_fail       <= 1'b0;
      locked_out     <= 1'b0;
      tries_left     <= TW'(MAX_TRIES);
    end else begin
      state          <= state_nxt;
      lock_status    <= lock_status | lock_req;
      debug_unlocked <= unlocked_nxt;
      dbg_ack        <= ack_nxt;
      dbg_fail       <= fail_nxt;
      locked_out     <= locked_out_nxt;
      tries_left     <= tries_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_CHALLENGE;
      ST_CHALLENGE: begin
        if (!debug_en)    state_nxt = ST_IDLE;
        else if (key_ok)  state_nxt = ST_UNLOCKED;
        else if (key_bad) state_nxt = last_try ? ST_LOCKOUT : ST_IDLE;
      end
      ST_UNLOCKED:  if (dbg_exit || session_expired || !debug_en) state_nxt = ST_IDLE;
      ST_LOCKOUT:   if (lockout_expired) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    unlocked_nxt   = (state_nxt == ST_UNLOCKED);
    locked_out_nxt = (state_nxt == ST_LOCKOUT);
    ack_nxt        = key_ok;
    fail_nxt       = key_bad;
    tries_nxt      = tries_left;
    if (key_ok)                                         tries_nxt = TW'(MAX_TRIES);
    else if (key_bad)                                   tries_nxt = tries_left - TW'(1);
    else if ((state == ST_LOCKOUT) && lockout_expired)  tries_nxt = TW'(MAX_TRIES);
  end

endmodule
